// File: rtl/i2c_seq_pkg.sv
// Shared constants for the i2c_master_top register sequencer: register offsets,
// CR/SR/CTR bit definitions, response codes and the transaction state encoding.
package i2c_seq_pkg;

  localparam logic [7:0] OFF_PRER_LO = 8'h00;
  localparam logic [7:0] OFF_PRER_HI = 8'h04;
  localparam logic [7:0] OFF_CTR     = 8'h08;
  localparam logic [7:0] OFF_TXR     = 8'h0C;
  localparam logic [7:0] OFF_RXR     = 8'h0C;
  localparam logic [7:0] OFF_CR      = 8'h10;
  localparam logic [7:0] OFF_SR      = 8'h10;

  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_ACK  = 8'h08;
  localparam logic [7:0] CR_IACK = 8'h01;

  localparam int SR_RXACK = 7;
  localparam int SR_TIP   = 1;
  localparam int SR_IF    = 0;

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CTR_IEN = 8'h40;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_INIT_LO,
    S_INIT_HI,
    S_INIT_CTR,
    S_IDLE,
    S_TXR,
    S_CR,
    S_WAIT,
    S_SR,
    S_IACK,
    S_STOP,
    S_RXR,
    S_RESP,
    S_DONE
  } state_e;

endpackage

// File: rtl/i2c_seq_apb_xfer.sv
// Single APB master transfer: setup cycle, access cycles until ready, then idle.
// done_o pulses (and rdata_o updates) the cycle after the access completes.
module i2c_seq_apb_xfer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        wr_i,
  input  logic [7:0]  offset_i,
  input  logic [7:0]  wdata_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        apb_sel_o,
  output logic        apb_en_o,
  output logic        apb_write_o,
  output logic [31:0] apb_addr_o,
  output logic [31:0] apb_wdata_o,
  input  logic [31:0] apb_rdata_i,
  input  logic        apb_ready_i
);

  logic        sel_q, en_q, write_q, done_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  rdata_q;

  // Only the low byte of the core's registers carries data.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^apb_rdata_i[31:8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (!sel_q) begin
        if (start_i) begin
          sel_q   <= 1'b1;
          write_q <= wr_i;
          addr_q  <= BASE_ADDR + {24'h0, offset_i};
          wdata_q <= {24'h0, wdata_i};
        end
      end else if (!en_q) begin
        en_q <= 1'b1;
      end else if (apb_ready_i) begin
        sel_q   <= 1'b0;
        en_q    <= 1'b0;
        done_q  <= 1'b1;
        rdata_q <= apb_rdata_i[7:0];
      end
    end
  end

  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign apb_sel_o   = sel_q;
  assign apb_en_o    = en_q;
  assign apb_write_o = write_q;
  assign apb_addr_o  = addr_q;
  assign apb_wdata_o = wdata_q;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Turns single-byte register read/write requests into i2c_master_top APB sequences.
// Optional I2C_SEQ_IRQ_WAIT_EN: wait for irq instead of polling SR, then IACK.
//   state      | meaning
//   S_INIT_*   | write PRER_LO, PRER_HI, CTR
//   S_IDLE     | req_ready=1, accept request
//   S_TXR      | write TXR with current byte
//   S_CR       | write CR command for current byte
//   S_WAIT     | poll SR (or wait for irq) until TIP=0
//   S_SR/IACK  | irq build: read SR, then acknowledge interrupt
//   S_STOP     | write CR=STO after NACK or timeout
//   S_RXR      | read received byte
//   S_RESP     | pulse rsp_valid
//   S_DONE     | drop busy, return to idle
module i2c_apb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'd199,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_reg_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  input  logic [31:0] apb_rdata,
  input  logic        apb_ready,
  input  logic        irq
);

`ifdef I2C_SEQ_IRQ_WAIT_EN
  localparam logic [7:0] CTR_INIT = CTR_EN | CTR_IEN;
`else
  localparam logic [7:0] CTR_INIT = CTR_EN;
`endif
  localparam logic [15:0] LIM_M1 = POLL_LIMIT - 16'd1;

  state_e      state_q;
  logic        issued_q, start_q, xwr_q;
  logic [7:0]  xoff_q, xdata_q;
  logic        req_wr_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdat_q, rd_data_q;
  logic [1:0]  byte_q, err_q;
  logic [15:0] poll_q;
  logic        stopping_q, ready_q, busy_q, rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic [1:0]  rsp_err_q;

  logic        xfer_done;
  logic [7:0]  xfer_rdata;
  logic        is_xfer, xwr_d;
  logic [7:0]  xoff_d, xdata_d, sr_val;
  logic        last_byte, last_rd;

`ifdef I2C_SEQ_IRQ_WAIT_EN
  logic [7:0]  sr_q;
  assign sr_val = sr_q;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign sr_val = xfer_rdata;
`endif

  assign last_rd   = !req_wr_q && (byte_q == 2'd3);
  assign last_byte = req_wr_q ? (byte_q == 2'd2) : (byte_q == 2'd3);

  // APB command implied by the current state; launched once per state visit.
  always_comb begin
    is_xfer = 1'b1;
    xwr_d   = 1'b1;
    xoff_d  = OFF_CR;
    xdata_d = 8'h00;
    case (state_q)
      S_INIT_LO: begin xoff_d = OFF_PRER_LO; xdata_d = PRESCALE[7:0]; end
      S_INIT_HI: begin xoff_d = OFF_PRER_HI; xdata_d = PRESCALE[15:8]; end
      S_INIT_CTR: begin xoff_d = OFF_CTR; xdata_d = CTR_INIT; end
      S_TXR: begin
        xoff_d = OFF_TXR;
        case (byte_q)
          2'd0:    xdata_d = {dev_q, 1'b0};
          2'd1:    xdata_d = reg_q;
          default: xdata_d = req_wr_q ? wdat_q : {dev_q, 1'b1};
        endcase
      end
      S_CR: begin
        case (byte_q)
          2'd0:    xdata_d = CR_STA | CR_WR;
          2'd1:    xdata_d = CR_WR;
          2'd2:    xdata_d = req_wr_q ? (CR_WR | CR_STO) : (CR_STA | CR_WR);
          default: xdata_d = CR_RD | CR_ACK | CR_STO;
        endcase
      end
`ifdef I2C_SEQ_IRQ_WAIT_EN
      S_SR:   begin xwr_d = 1'b0; xoff_d = OFF_SR; end
      S_IACK: xdata_d = CR_IACK;
`else
      S_WAIT: begin xwr_d = 1'b0; xoff_d = OFF_SR; end
`endif
      S_STOP: xdata_d = CR_STO;
      S_RXR:  begin xwr_d = 1'b0; xoff_d = OFF_RXR; end
      default: is_xfer = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_INIT_LO;
      issued_q    <= 1'b0;
      start_q     <= 1'b0;
      xwr_q       <= 1'b0;
      xoff_q      <= 8'h00;
      xdata_q     <= 8'h00;
      req_wr_q    <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdat_q      <= 8'h00;
      rd_data_q   <= 8'h00;
      byte_q      <= 2'd0;
      err_q       <= ERR_OK;
      poll_q      <= 16'h0;
      stopping_q  <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= ERR_OK;
`ifdef I2C_SEQ_IRQ_WAIT_EN
      sr_q        <= 8'h00;
`endif
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (is_xfer && !issued_q) begin
        start_q  <= 1'b1;
        issued_q <= 1'b1;
        xwr_q    <= xwr_d;
        xoff_q   <= xoff_d;
        xdata_q  <= xdata_d;
      end
      if (xfer_done) issued_q <= 1'b0;

      case (state_q)
        S_INIT_LO:  if (xfer_done) state_q <= S_INIT_HI;
        S_INIT_HI:  if (xfer_done) state_q <= S_INIT_CTR;
        S_INIT_CTR: if (xfer_done) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        S_IDLE: if (req_valid && ready_q) begin
          req_wr_q   <= req_wr;
          dev_q      <= req_dev_addr;
          reg_q      <= req_reg_addr;
          wdat_q     <= req_wdata;
          ready_q    <= 1'b0;
          busy_q     <= 1'b1;
          byte_q     <= 2'd0;
          err_q      <= ERR_OK;
          stopping_q <= 1'b0;
          rd_data_q  <= 8'h00;
          state_q    <= S_TXR;
        end
        S_TXR: if (xfer_done) state_q <= S_CR;
        S_CR:  if (xfer_done) begin
          poll_q  <= 16'h0;
          state_q <= S_WAIT;
        end
`ifdef I2C_SEQ_IRQ_WAIT_EN
        S_WAIT: begin
          if (irq) state_q <= S_SR;
          else if (poll_q == LIM_M1) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= stopping_q ? S_RESP : S_STOP;
          end else poll_q <= poll_q + 16'd1;
        end
        S_SR: if (xfer_done) begin
          sr_q    <= xfer_rdata;
          state_q <= S_IACK;
        end
        S_IACK: if (xfer_done) begin
`else
        S_WAIT: if (xfer_done) begin
`endif
          if (sr_val[SR_TIP]) begin
`ifdef I2C_SEQ_IRQ_WAIT_EN
            state_q <= S_WAIT;
`else
            if (poll_q == LIM_M1) begin
              err_q   <= ERR_TIMEOUT;
              state_q <= stopping_q ? S_RESP : S_STOP;
            end else poll_q <= poll_q + 16'd1;
`endif
          end else if (stopping_q) begin
            state_q <= S_RESP;
          end else if (sr_val[SR_RXACK] && !last_rd) begin
            err_q   <= ERR_NACK;
            state_q <= S_STOP;
          end else if (last_byte) begin
            state_q <= req_wr_q ? S_RESP : S_RXR;
          end else begin
            byte_q  <= byte_q + 2'd1;
            // The final read byte is a bare CR command with no TXR load.
            state_q <= (!req_wr_q && byte_q == 2'd2) ? S_CR : S_TXR;
          end
        end
        S_STOP: if (xfer_done) begin
          if (err_q == ERR_TIMEOUT) state_q <= S_RESP;
          else begin
            stopping_q <= 1'b1;
            poll_q     <= 16'h0;
            state_q    <= S_WAIT;
          end
        end
        S_RXR: if (xfer_done) begin
          rd_data_q <= xfer_rdata;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= rd_data_q;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT_LO;
      endcase
    end
  end

  i2c_seq_apb_xfer #(.BASE_ADDR(BASE_ADDR)) u_xfer (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .start_i     (start_q),
    .wr_i        (xwr_q),
    .offset_i    (xoff_q),
    .wdata_i     (xdata_q),
    .done_o      (xfer_done),
    .rdata_o     (xfer_rdata),
    .apb_sel_o   (apb_sel),
    .apb_en_o    (apb_en),
    .apb_write_o (apb_write),
    .apb_addr_o  (apb_addr),
    .apb_wdata_o (apb_wdata),
    .apb_rdata_i (apb_rdata),
    .apb_ready_i (apb_ready)
  );

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Scoreboard bench for i2c_apb_sequencer: a scripted APB slave model, expected
// APB transfers and responses queued by the stimulus, checked by a monitor.
module tb_i2c_apb_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [6:0]  req_dev_addr = 7'h00;
  logic [7:0]  req_reg_addr = 8'h00;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_ready, rsp_valid, busy;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        apb_sel, apb_en, apb_write, apb_ready;
  logic [31:0] apb_addr, apb_wdata, apb_rdata;
  logic        irq = 1'b0;

  always #5 clk = ~clk;

  i2c_apb_sequencer #(.POLL_LIMIT(16'd8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata),
    .apb_ready(apb_ready), .irq(irq)
  );

  typedef struct packed { logic wr; logic [7:0] off; logic [7:0] data; } apb_t;
  typedef struct packed { logic [1:0] err; logic chk_rd; logic [7:0] rdata; } rsp_t;
  apb_t exp_apb[$];
  rsp_t exp_rsp[$];
  int n_tests = 0;
  int n_fail  = 0;

  // APB slave model: programmable wait states and SR behaviour.
  int         stall_cfg = 0;
  int         wcnt = 0;
  int         sr_mode = 0;
  int         sr_reads = 0;
  int         sr_base = 0;
  logic [7:0] rxr_val = 8'h00;
  logic [7:0] last_cr = 8'h00;

  assign apb_ready = apb_sel && apb_en && (wcnt >= stall_cfg);

  always_comb begin
    apb_rdata = 32'h0;
    if (apb_addr == 32'h10) begin
      case (sr_mode)
        1: apb_rdata = (sr_reads == sr_base) ? 32'h80 : 32'h00;
        2: apb_rdata = 32'h02;
        3: apb_rdata = (last_cr == 8'h68) ? 32'h80 : 32'h00;
        default: apb_rdata = 32'h00;
      endcase
    end else if (apb_addr == 32'h0C) begin
      apb_rdata = {24'h0, rxr_val};
    end
  end

  always @(posedge clk) begin
    if (apb_sel && apb_en && !apb_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (apb_sel && apb_en && apb_ready) begin
      if (!apb_write && apb_addr == 32'h10) sr_reads <= sr_reads + 1;
      if (apb_write && apb_addr == 32'h10) last_cr <= apb_wdata[7:0];
    end
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: APB completions and responses, sampled on the falling edge.
  logic [31:0] snap_addr = 32'h0, snap_wdata = 32'h0;
  logic        snap_write = 1'b0, stable = 1'b1, rsp_seen = 1'b0;
  int          acc = 0, apb_done = 0, rsp_cnt = 0;
  apb_t        e;
  rsp_t        r;

  initial forever begin
    @(negedge clk);
    if (resetn && apb_sel) begin
      if (!apb_en) begin
        snap_addr = apb_addr; snap_wdata = apb_wdata; snap_write = apb_write;
        acc = 0; stable = 1'b1;
      end else begin
        acc++;
        if (apb_addr != snap_addr || apb_wdata != snap_wdata || apb_write != snap_write) stable = 1'b0;
        if (apb_ready) begin
          apb_done++;
          n_tests++;
          if (!stable || acc != stall_cfg + 1) begin
            n_fail++;
            $display("FAIL apb_timing: access_cycles=%0d stable=%0b, expected access_cycles=%0d stable=1",
                     acc, stable, stall_cfg + 1);
          end
          n_tests++;
          if (exp_apb.size() == 0) begin
            n_fail++;
            $display("FAIL apb_xfer: got wr=%0b addr=%h wdata=%h, expected no transfer",
                     apb_write, apb_addr, apb_wdata);
          end else begin
            e = exp_apb.pop_front();
            if (apb_write !== e.wr || apb_addr !== {24'h0, e.off} ||
                (e.wr && apb_wdata !== {24'h0, e.data})) begin
              n_fail++;
              $display("FAIL apb_xfer: got wr=%0b addr=%h wdata=%h, expected wr=%0b addr=%h wdata=%h",
                       apb_write, apb_addr, apb_wdata, e.wr, {24'h0, e.off}, {24'h0, e.data});
            end
          end
        end
      end
    end
    if (rsp_seen) begin
      rsp_seen = 1'b0;
      chk(rsp_valid === 1'b0 && busy === 1'b0 && req_ready === 1'b1, "rsp_tail",
          {29'h0, rsp_valid, busy, req_ready}, 32'h1);
    end
    if (resetn && rsp_valid) begin
      rsp_cnt++;
      rsp_seen = 1'b1;
      n_tests++;
      if (exp_rsp.size() == 0) begin
        n_fail++;
        $display("FAIL rsp: got err=%0d rdata=%h, expected no response", rsp_err, rsp_rdata);
      end else begin
        r = exp_rsp.pop_front();
        if (rsp_err !== r.err || busy !== 1'b1 || (r.chk_rd && rsp_rdata !== r.rdata)) begin
          n_fail++;
          $display("FAIL rsp: got err=%0d rdata=%h busy=%0b, expected err=%0d rdata=%h busy=1",
                   rsp_err, rsp_rdata, busy, r.err, r.rdata);
        end
      end
    end
  end

  task automatic push_w(input logic [7:0] off, input logic [7:0] d);
    exp_apb.push_back(apb_t'{wr: 1'b1, off: off, data: d});
  endtask
  task automatic push_r(input logic [7:0] off);
    exp_apb.push_back(apb_t'{wr: 1'b0, off: off, data: 8'h00});
  endtask
  task automatic exp_byte(input logic [7:0] txr, input logic [7:0] cr);
    push_w(8'h0C, txr); push_w(8'h10, cr); push_r(8'h10);
  endtask
  task automatic push_init();
    push_w(8'h00, 8'hC7); push_w(8'h04, 8'h00); push_w(8'h08, 8'h80);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk(req_ready === 1'b1, name, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic do_req(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] d, input string name);
    int target;
    wait_ready({name, "_ready"});
    target = rsp_cnt + 1;
    req_valid = 1'b1; req_wr = wr; req_dev_addr = dev; req_reg_addr = rg; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_cnt >= target) break;
    end
    chk(rsp_cnt >= target, {name, "_rsp_seen"}, rsp_cnt, target);
    repeat (3) @(negedge clk);
    chk(exp_apb.size() == 0, {name, "_leftover"}, exp_apb.size(), 0);
  endtask

  initial begin
    int base;
    #2 resetn = 1'b0;
    #1;
    chk({busy, req_ready, rsp_valid, apb_sel, apb_en, apb_write, rsp_err} == 8'b1000_0000 &&
        apb_addr == 32'h0 && apb_wdata == 32'h0 && rsp_rdata == 8'h00, "reset_state",
        {24'h0, busy, req_ready, rsp_valid, apb_sel, apb_en, apb_write, rsp_err}, 32'h80);
    push_init();
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    wait_ready("init_ready");
    chk(busy === 1'b0, "init_busy", {31'h0, busy}, 32'h0);
    chk(exp_apb.size() == 0, "init_leftover", exp_apb.size(), 0);

    // Plain write, all ACK.
    exp_byte(8'hA0, 8'h90); exp_byte(8'h10, 8'h10); exp_byte(8'hA5, 8'h50);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b0, rdata: 8'h00});
    do_req(1'b1, 7'h50, 8'h10, 8'hA5, "write");

    // Plain read.
    rxr_val = 8'h3C;
    exp_byte(8'hA0, 8'h90); exp_byte(8'h02, 8'h10); exp_byte(8'hA1, 8'h90);
    push_w(8'h10, 8'h68); push_r(8'h10); push_r(8'h0C);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b1, rdata: 8'h3C});
    do_req(1'b0, 7'h50, 8'h02, 8'h00, "read");

    // Master NACK on the final read byte leaves RxACK=1, which must be ignored.
    sr_mode = 3; rxr_val = 8'h5A;
    exp_byte(8'h56, 8'h90); exp_byte(8'h7F, 8'h10); exp_byte(8'h57, 8'h90);
    push_w(8'h10, 8'h68); push_r(8'h10); push_r(8'h0C);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b1, rdata: 8'h5A});
    do_req(1'b0, 7'h2B, 8'h7F, 8'h00, "read_last_nack");

    // Address NACK.
    sr_mode = 1; sr_base = sr_reads;
    push_w(8'h0C, 8'hA0); push_w(8'h10, 8'h90); push_r(8'h10);
    push_w(8'h10, 8'h40); push_r(8'h10);
    exp_rsp.push_back(rsp_t'{err: 2'd1, chk_rd: 1'b0, rdata: 8'h00});
    do_req(1'b1, 7'h50, 8'h10, 8'h11, "addr_nack");

    // TIP stuck: exactly POLL_LIMIT SR reads, then STO without waiting.
    sr_mode = 2;
    push_w(8'h0C, 8'hA0); push_w(8'h10, 8'h90);
    for (int i = 0; i < 8; i++) push_r(8'h10);
    push_w(8'h10, 8'h40);
    exp_rsp.push_back(rsp_t'{err: 2'd2, chk_rd: 1'b0, rdata: 8'h00});
    do_req(1'b1, 7'h50, 8'h10, 8'h22, "timeout");
    sr_mode = 0;

    // Five wait states per access.
    stall_cfg = 5;
    exp_byte(8'h42, 8'h90); exp_byte(8'h33, 8'h10); exp_byte(8'h0F, 8'h50);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b0, rdata: 8'h00});
    do_req(1'b1, 7'h21, 8'h33, 8'h0F, "stall");
    stall_cfg = 0;

    // Reset mid-read.
    rxr_val = 8'h3C;
    exp_byte(8'hA0, 8'h90); exp_byte(8'h02, 8'h10); exp_byte(8'hA1, 8'h90);
    push_w(8'h10, 8'h68); push_r(8'h10); push_r(8'h0C);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b1, rdata: 8'h3C});
    wait_ready("abort_ready");
    base = apb_done;
    req_valid = 1'b1; req_wr = 1'b0; req_dev_addr = 7'h50; req_reg_addr = 8'h02;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (apb_done >= base + 4 && apb_sel) break;
    end
    chk(apb_done >= base + 4 && apb_sel === 1'b1, "abort_reach", apb_done - base, 4);
    base = rsp_cnt;
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    chk({apb_sel, apb_en, apb_write, busy, req_ready} == 5'b00010 && apb_addr == 32'h0 &&
        apb_wdata == 32'h0, "abort_outputs", {27'h0, apb_sel, apb_en, apb_write, busy, req_ready}, 32'h2);
    exp_apb.delete();
    exp_rsp.delete();
    push_init();
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    wait_ready("reinit_ready");
    chk(exp_apb.size() == 0, "reinit_leftover", exp_apb.size(), 0);
    chk(rsp_cnt == base, "abort_no_rsp", rsp_cnt, base);

    // Normal operation after re-init.
    exp_byte(8'hA0, 8'h90); exp_byte(8'h10, 8'h10); exp_byte(8'h5C, 8'h50);
    exp_rsp.push_back(rsp_t'{err: 2'd0, chk_rd: 1'b0, rdata: 8'h00});
    do_req(1'b1, 7'h50, 8'h10, 8'h5C, "write_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
